// File: rtl/riscv_pkg.sv
// riscv_pkg: constants, the fetch FSM state type and the IF/ID record that the
// instruction-fetch slice shares.
// Contents: PC_W, INSTR_W, NOP_ENC, fetch_state_e, ifid_t, pc_align(), ifid_bubble().
package riscv_pkg;

    // Architectural PC width.
    localparam int unsigned PC_W    = 64;
    localparam int unsigned INSTR_W = 32;

    // addi x0, x0, 0. This is the canonical bubble placed in IF/ID.
    localparam logic [INSTR_W-1:0] NOP_ENC = 32'h0000_0013;

    // Sequential PC step for 32-bit instructions.
    localparam logic [PC_W-1:0] PC_STEP = 64'd4;

    // BOOT is a single cycle after reset in which PC holds and IF/ID is a bubble.
    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    // Contents of the IF/ID pipeline register.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               valid;
    } ifid_t;

    // Force a redirect target onto a 4-byte boundary. Masking the low bits
    // consumes the whole target, so no bits are left dangling.
    function automatic logic [PC_W-1:0] pc_align(input logic [PC_W-1:0] addr);
        return addr & ~64'h3;
    endfunction

    // Build a flushed IF/ID record that carries the given NOP encoding.
    function automatic ifid_t ifid_bubble(input logic [INSTR_W-1:0] nop);
        ifid_t b;
        b.pc    = '0;
        b.instr = nop;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage : riscv_pkg

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: groups the fetch unit's control, memory and IF/ID signals.
// master: fetch unit side. slave: hazard unit, EX stage, instruction memory and decode side.
// Optional: fetch_count exists only when IFETCH_PERF_CNT_EN is defined.
interface instruction_fetch_if;
    import riscv_pkg::*;

    // Control from the hazard unit and the EX stage.
    logic                stall;
    logic                branch_taken;
    logic [PC_W-1:0]     branch_target;

    // Instruction memory.
    logic [PC_W-1:0]     Inst_Address;
    logic [INSTR_W-1:0]  Instruction;

    // IF/ID register toward decode.
    logic [PC_W-1:0]     IFID_PC;
    logic [INSTR_W-1:0]  IFID_Instruction;
    logic                IFID_valid;

`ifdef IFETCH_PERF_CNT_EN
    logic [63:0]         fetch_count;
`endif

    modport master (
        input  stall,
        input  branch_taken,
        input  branch_target,
        input  Instruction,
        output Inst_Address,
        output IFID_PC,
        output IFID_Instruction,
`ifdef IFETCH_PERF_CNT_EN
        output fetch_count,
`endif
        output IFID_valid
    );

    modport slave (
        output stall,
        output branch_taken,
        output branch_target,
        output Instruction,
        input  Inst_Address,
        input  IFID_PC,
        input  IFID_Instruction,
`ifdef IFETCH_PERF_CNT_EN
        input  fetch_count,
`endif
        input  IFID_valid
    );

endinterface : instruction_fetch_if

// File: rtl/instruction_fetch_if_id_reg.sv
// if_id_reg: the IF/ID pipeline register with load, flush and hold controls.
// Ports: clk, reset, load_i, flush_i, pc_i, instr_i in; ifid_o out (registered record).
// flush_i takes priority over load_i. With neither asserted the register holds.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_ENC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_i,
    input  logic                flush_i,
    input  logic [PC_W-1:0]     pc_i,
    input  logic [INSTR_W-1:0]  instr_i,
    output ifid_t               ifid_o
);
    // purpose: one-deep IF/ID pipeline register.
    // latency: one cycle from load/flush to ifid_o.
    // backpressure: deasserting both controls holds the contents (stall).

    ifid_t ifid_q;
    ifid_t ifid_d;

    always_comb begin
        ifid_d = ifid_q;
        if (flush_i) begin
            ifid_d = ifid_bubble(NOP_INSTR);
        end else if (load_i) begin
            ifid_d.pc    = pc_i;
            ifid_d.instr = instr_i;
            ifid_d.valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_q <= ifid_bubble(NOP_INSTR);
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign ifid_o = ifid_q;

endmodule : if_id_reg

// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage. Holds the PC and the BOOT/RUN FSM, and drives IF/ID through if_id_reg.
// Ports: clk, reset (sync, active high); bus (instruction_fetch_if.master) carrying stall/branch,
// imem address/data and IF/ID outputs. Optional IFETCH_PERF_CNT_EN adds the fetch_count counter.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC  = 64'h0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_ENC
) (
    input  logic                 clk,
    input  logic                 reset,
    instruction_fetch_if.master  bus
);
    // purpose: PC sequencing with redirect, stall hold and IF/ID capture.
    // latency: Inst_Address comes straight from the PC register; IF/ID lags the PC by one edge.
    // backpressure: stall holds the PC and IF/ID; branch_taken overrides stall and flushes IF/ID.

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            ifid_load;
    logic            ifid_flush;
    ifid_t           ifid;

    // Next state, next PC and IF/ID controls. A redirect outranks a stall, so
    // a stalled instruction can never survive a taken branch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        unique case (state_q)
            BOOT: begin
                // Memory gets one full cycle at RESET_PC. Stall and branch are ignored here.
                state_d    = RUN;
                ifid_flush = 1'b1;
            end
            RUN: begin
                if (bus.branch_taken) begin
                    pc_d       = pc_align(bus.branch_target);
                    ifid_flush = 1'b1;
                end else if (!bus.stall) begin
                    // The add wraps naturally at 2^64.
                    pc_d      = pc_q + PC_STEP;
                    ifid_load = 1'b1;
                end
            end
            default: begin
                state_d    = BOOT;
                ifid_flush = 1'b1;
            end
        endcase
    end

    // Reset wins over every other control and discards in-flight state on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk      (clk),
        .reset    (reset),
        .load_i   (ifid_load),
        .flush_i  (ifid_flush),
        .pc_i     (pc_q),
        .instr_i  (bus.Instruction),
        .ifid_o   (ifid)
    );

    assign bus.Inst_Address     = pc_q;
    assign bus.IFID_PC          = ifid.pc;
    assign bus.IFID_Instruction = ifid.instr;
    assign bus.IFID_valid       = ifid.valid;

`ifdef IFETCH_PERF_CNT_EN
    // Counts the edges on which IF/ID captures a real instruction. Flushes and stalls are not counted.
    logic [63:0] fetch_cnt_q;
    logic [63:0] fetch_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        if (ifid_load && !ifid_flush) begin
            fetch_cnt_d = fetch_cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign bus.fetch_count = fetch_cnt_q;
`endif

endmodule : instruction_fetch

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013 (addi x0 x0 0), meaning the bubble injected into IF/ID.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port stall, input, 1, hazard-unit request to hold PC and IF/ID.
REQ-006 SHALL have port branch_taken, input, 1, redirect request from EX.
REQ-007 SHALL have port branch_target, input, 64, redirect address.
REQ-008 SHALL have port Inst_Address, output, 64, current PC driven to instruction memory.
REQ-009 SHALL have port Instruction, input, 32, combinational instruction-memory read data for Inst_Address.
REQ-010 SHALL have port IFID_PC, output, 64, PC of the instruction held in IF/ID.
REQ-011 SHALL have port IFID_Instruction, output, 32, instruction held in IF/ID.
REQ-012 SHALL have port IFID_valid, output, 1, high when IF/ID holds a real (non-bubble) instruction.

Function
REQ-013 SHALL implement FSM states BOOT and RUN; reset enters BOOT; BOOT goes to RUN unconditionally after one cycle.
REQ-014 SHALL hold PC at RESET_PC in BOOT and capture a bubble into IF/ID (IFID_valid=0).
REQ-015 SHALL drive Inst_Address directly from the PC register; zero combinational latency to memory.
REQ-016 SHALL, in RUN with no stall and no branch, load PC <= PC+4 (64-bit, wrap modulo 2^64) and load IF/ID with {PC, Instruction}, valid=1.
REQ-017 SHALL, in RUN with stall=1 and branch_taken=0, hold PC, IFID_PC, IFID_Instruction and IFID_valid unchanged.
REQ-018 SHALL, on branch_taken=1, load PC <= {branch_target[63:2],2'b00} and load IF/ID with NOP_INSTR, IFID_PC=0, valid=0 (flush).
REQ-019 SHALL give branch_taken priority over stall when both are high in the same cycle.
REQ-020 SHALL give reset priority over branch_taken and stall.
REQ-021 SHALL ignore branch_taken and stall while in BOOT.
REQ-022 SHALL produce first valid IF/ID contents (IFID_PC=RESET_PC) two rising edges after reset deasserts.

Reset
REQ-023 SHALL on reset set PC=RESET_PC, IFID_PC=0, IFID_Instruction=NOP_INSTR, IFID_valid=0, state=BOOT.
REQ-024 SHALL, when reset asserts mid-stream (including during stall or branch), discard all in-flight state on that edge.

Configuration
REQ-025 SHALL, with IFETCH_PERF_CNT_EN defined, provide output fetch_count (64-bit) that increments on every edge where IF/ID loads a valid instruction, resets to 0, wraps at 2^64.
REQ-026 SHALL, without IFETCH_PERF_CNT_EN, omit the fetch_count port and counter entirely.

Structure
REQ-027 SHALL place the NOP encoding, the FSM state enumeration and the PC width constant (64) in the shared package riscv_pkg.
REQ-028 SHALL implement the IF/ID register as sub-module if_id_reg (load, flush, hold controls); PC and FSM stay in the top.

Verification
REQ-029 SHALL check reset release with RESET_PC=0: Inst_Address 0,0,4,8 on successive cycles; IFID_valid rises on the second edge with IFID_PC=0.
REQ-030 SHALL check stall held 3 cycles at PC=8: Inst_Address stays 8, IFID_PC stays 4, IFID_valid stays 1; PC=12 the cycle after release.
REQ-031 SHALL check branch_taken with target 64'h40 at PC=16: next Inst_Address=0x40, IFID_Instruction=32'h00000013, IFID_valid=0.
REQ-032 SHALL check branch_taken and stall together with target 0x21: PC becomes 0x20, IF/ID flushed.
REQ-033 SHALL check reset asserted during stall at PC=0x100: next cycle PC=RESET_PC, state BOOT, IFID_valid=0.
REQ-034 SHALL check with IFETCH_PERF_CNT_EN defined that 5 valid fetches, 2 stall cycles and 1 flush yield fetch_count=5.
